cfir29_engine: RTL and testbench

- Complex-valued, 29-tap, linear-phase (symmetric) FIR filter engine.
- Input samples enter through an elastic FIFO. A control FSM pulls one sample at a time into a 29-deep delay line.
- A time-multiplexed datapath of 5 complex multipliers computes one filtered complex output per accepted sample.
- Sits between the sample source (PushIn/StopIn handshake) and the downstream consumer (PushOut, no backpressure).

---
 rtl/cfir29_engine.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cfir29_engine.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfir29_engine.sv
// Complex 29-tap symmetric FIR engine: input FIFO, 29-deep delay line and
// five time-shared complex MACs that produce one rounded output per sample.
module cfir29_engine #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               PushIn,
  output logic               StopIn,
  input  logic signed [23:0] SampI,
  input  logic signed [23:0] SampQ,
  input  logic               PushCoef,
  input  logic        [4:0]  CoefAddr,
  input  logic signed [26:0] CoefI,
  input  logic signed [26:0] CoefQ,
  output logic               PushOut,
  output logic signed [31:0] FI,
  output logic signed [31:0] FQ,
  output logic        [2:0]  dbg_state_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ACC_W = 58;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(4194304);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    G0   = 3'd1,
    G1   = 3'd2,
    G2   = 3'd3,
    RND  = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   pull;

  // ---------------- input FIFO ----------------
  // Handshake: a sample is taken on a rising edge where PushIn=1 and StopIn=0;
  // StopIn reflects the registered count, so a pull in the same cycle does not
  // free space for that push.
  logic [47:0]   fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          fifo_empty;
  logic [47:0]   head;

  assign StopIn     = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push_ok    = PushIn && !StopIn;
  assign head       = fifo_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= {SampI, SampQ};
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pull)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pull)      count_q <= count_q + 1'b1;
      else if (pull && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pull    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pull    = 1'b1;
          state_d = G0;
        end
      end
      G0:      state_d = G1;
      G1:      state_d = G2;
      G2:      state_d = RND;
      RND:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state_o = state_q;

  // ---------------- delay line ----------------
  logic signed [23:0] s_i_q [29];
  logic signed [23:0] s_q_q [29];

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 29; i++) begin
        s_i_q[i] <= '0;
        s_q_q[i] <= '0;
      end
    end else if (pull) begin
      s_i_q[0] <= head[47:24];
      s_q_q[0] <= head[23:0];
      for (int i = 1; i < 29; i++) begin
        s_i_q[i] <= s_i_q[i-1];
        s_q_q[i] <= s_q_q[i-1];
      end
    end
  end

  // ---------------- coefficient banks ----------------
  // The active bank only follows the shadow bank while idle, so writes
  // landing mid-computation wait for the next sample.
  logic signed [26:0] shd_i_q [15];
  logic signed [26:0] shd_q_q [15];
  logic signed [26:0] act_i_q [15];
  logic signed [26:0] act_q_q [15];

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < 15; k++) begin
        shd_i_q[k] <= '0;
        shd_q_q[k] <= '0;
        act_i_q[k] <= '0;
        act_q_q[k] <= '0;
      end
    end else begin
      if (PushCoef && (CoefAddr < 5'd15)) begin
        shd_i_q[CoefAddr[3:0]] <= CoefI;
        shd_q_q[CoefAddr[3:0]] <= CoefQ;
      end
      if (state_q == IDLE) begin
        for (int k = 0; k < 15; k++) begin
          act_i_q[k] <= shd_i_q[k];
          act_q_q[k] <= shd_q_q[k];
        end
      end
    end
  end

  // ---------------- symmetric pre-adders ----------------
  logic signed [24:0] pre_i [15];
  logic signed [24:0] pre_q [15];

  always_comb begin
    for (int k = 0; k < 14; k++) begin
      pre_i[k] = {s_i_q[k][23], s_i_q[k]} + {s_i_q[28-k][23], s_i_q[28-k]};
      pre_q[k] = {s_q_q[k][23], s_q_q[k]} + {s_q_q[28-k][23], s_q_q[28-k]};
    end
    pre_i[14] = {s_i_q[14][23], s_i_q[14]};
    pre_q[14] = {s_q_q[14][23], s_q_q[14]};
  end

  // ---------------- tap-group operand select ----------------
  logic signed [24:0] op_i [5];
  logic signed [24:0] op_q [5];
  logic signed [26:0] cf_i [5];
  logic signed [26:0] cf_q [5];

  always_comb begin
    for (int j = 0; j < 5; j++) begin
      op_i[j] = '0;
      op_q[j] = '0;
      cf_i[j] = '0;
      cf_q[j] = '0;
      case (state_q)
        G0: begin
          op_i[j] = pre_i[j];     op_q[j] = pre_q[j];
          cf_i[j] = act_i_q[j];   cf_q[j] = act_q_q[j];
        end
        G1: begin
          op_i[j] = pre_i[5+j];   op_q[j] = pre_q[5+j];
          cf_i[j] = act_i_q[5+j]; cf_q[j] = act_q_q[5+j];
        end
        G2: begin
          op_i[j] = pre_i[10+j];   op_q[j] = pre_q[10+j];
          cf_i[j] = act_i_q[10+j]; cf_q[j] = act_q_q[10+j];
        end
        default: ;
      endcase
    end
  end

  // ---------------- complex multipliers and group sum ----------------
  logic signed [51:0]      p_ac [5];
  logic signed [51:0]      p_bd [5];
  logic signed [51:0]      p_ad [5];
  logic signed [51:0]      p_bc [5];
  logic signed [ACC_W-1:0] sum_i, sum_q;

  always_comb begin
    sum_i = '0;
    sum_q = '0;
    for (int j = 0; j < 5; j++) begin
      p_ac[j] = 52'(op_i[j]) * 52'(cf_i[j]);
      p_bd[j] = 52'(op_q[j]) * 52'(cf_q[j]);
      p_ad[j] = 52'(op_i[j]) * 52'(cf_q[j]);
      p_bc[j] = 52'(op_q[j]) * 52'(cf_i[j]);
      sum_i   = sum_i + ACC_W'(p_ac[j]) - ACC_W'(p_bd[j]);
      sum_q   = sum_q + ACC_W'(p_ad[j]) + ACC_W'(p_bc[j]);
    end
  end

  // ---------------- accumulators ----------------
  logic signed [ACC_W-1:0] acc_i_q, acc_q_q;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
    end else begin
      case (state_q)
        G0: begin
          acc_i_q <= sum_i;
          acc_q_q <= sum_q;
        end
        G1, G2: begin
          acc_i_q <= acc_i_q + sum_i;
          acc_q_q <= acc_q_q + sum_q;
        end
        default: ;
      endcase
    end
  end

  // ---------------- round-half-up and output register ----------------
  logic signed [ACC_W-1:0] rnd_i, rnd_q;
  logic                    push_out_q;
  logic signed [31:0]      fi_q, fq_q;
  logic                    unused_rnd_bits;

  assign rnd_i = acc_i_q + RND_HALF;
  assign rnd_q = acc_q_q + RND_HALF;
  assign unused_rnd_bits = ^{rnd_i[ACC_W-1:55], rnd_i[22:0],
                             rnd_q[ACC_W-1:55], rnd_q[22:0]};

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      push_out_q <= 1'b0;
      fi_q       <= '0;
      fq_q       <= '0;
    end else begin
      push_out_q <= (state_q == RND);
      if (state_q == RND) begin
        fi_q <= rnd_i[54:23];
        fq_q <= rnd_q[54:23];
      end
    end
  end

  assign PushOut = push_out_q;
  assign FI      = fi_q;
  assign FQ      = fq_q;

endmodule

// File: tb/tb_cfir29_engine.sv
// Bench for cfir29_engine: directed filter cases plus a scoreboard fed by a
// direct-form reference model of the 29-tap complex filter.
module tb_cfir29_engine;

  localparam int FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        Reset;
  logic        PushIn, StopIn, PushCoef, PushOut;
  logic [23:0] SampI, SampQ;
  logic [4:0]  CoefAddr;
  logic [26:0] CoefI, CoefQ;
  logic [31:0] FI, FQ;
  logic [2:0]  dbg_state;

  cfir29_engine #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .PushIn     (PushIn),
    .StopIn     (StopIn),
    .SampI      (SampI),
    .SampQ      (SampQ),
    .PushCoef   (PushCoef),
    .CoefAddr   (CoefAddr),
    .CoefI      (CoefI),
    .CoefQ      (CoefQ),
    .PushOut    (PushOut),
    .FI         (FI),
    .FQ         (FQ),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          out_cnt  = 0;
  logic [31:0] last_fi, last_fq;
  logic [63:0] exp_q[$];
  int          out_cyc_q[$];

  longint m_si [29];
  longint m_sq [29];
  longint m_ci [15];
  longint m_cq [15];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int k = 0; k < 29; k++) begin
      m_si[k] = 0;
      m_sq[k] = 0;
    end
    for (int k = 0; k < 15; k++) begin
      m_ci[k] = 0;
      m_cq[k] = 0;
    end
    exp_q.delete();
    out_cyc_q.delete();
  endtask

  task automatic model_push(input logic [23:0] si, input logic [23:0] sq);
    longint      ai, aq;
    int          c;
    logic [31:0] fi, fq;
    for (int k = 28; k > 0; k--) begin
      m_si[k] = m_si[k-1];
      m_sq[k] = m_sq[k-1];
    end
    m_si[0] = longint'($signed(si));
    m_sq[0] = longint'($signed(sq));
    ai = 0;
    aq = 0;
    for (int k = 0; k < 29; k++) begin
      c  = (k <= 14) ? k : 28 - k;
      ai = ai + m_ci[c] * m_si[k] - m_cq[c] * m_sq[k];
      aq = aq + m_ci[c] * m_sq[k] + m_cq[c] * m_si[k];
    end
    fi = 32'((ai + 64'sd4194304) >>> 23);
    fq = 32'((aq + 64'sd4194304) >>> 23);
    exp_q.push_back({fi, fq});
  endtask

  // ---------------- output monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!Reset && PushOut) begin
      logic [63:0] e;
      out_cnt++;
      last_fi = FI;
      last_fq = FQ;
      out_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pushout", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_fi", FI, e[63:32]);
        check_eq("sb_fq", FQ, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_coef_now(input logic [4:0] a, input logic [26:0] ci, input logic [26:0] cq);
    PushCoef = 1'b1;
    CoefAddr = a;
    CoefI    = ci;
    CoefQ    = cq;
    if (a < 5'd15) begin
      m_ci[a[3:0]] = longint'($signed(ci));
      m_cq[a[3:0]] = longint'($signed(cq));
    end
    @(negedge clk);
    PushCoef = 1'b0;
  endtask

  task automatic write_coef(input logic [4:0] a, input logic [26:0] ci, input logic [26:0] cq);
    @(negedge clk);
    write_coef_now(a, ci, cq);
  endtask

  // Drives one push cycle; a push counts as accepted when StopIn is low.
  task automatic push_sample(input logic [23:0] si, input logic [23:0] sq, output logic ok);
    @(negedge clk);
    PushIn = 1'b1;
    SampI  = si;
    SampQ  = sq;
    ok     = !StopIn;
    if (ok) model_push(si, sq);
  endtask

  task automatic stop_push();
    @(negedge clk);
    PushIn = 1'b0;
  endtask

  task automatic wait_outs(input int target, input int budget);
    int n = 0;
    while (out_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq("out_timeout", 64'(out_cnt >= target), 1);
  endtask

  task automatic send_one(input logic [23:0] si, input logic [23:0] sq);
    int   target;
    logic ok;
    target = out_cnt + 1;
    push_sample(si, sq, ok);
    stop_push();
    wait_outs(target, 30);
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset    = 1'b1;
    PushIn   = 1'b0;
    PushCoef = 1'b0;
    model_clear();
    @(negedge clk);
    Reset = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic ok;
    int   target, c_push, n_acc, cnt_before;

    Reset = 1'b1; PushIn = 1'b0; PushCoef = 1'b0;
    SampI = '0; SampQ = '0; CoefAddr = '0; CoefI = '0; CoefQ = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_eq("rst_stopin",  StopIn,    0);
    check_eq("rst_pushout", PushOut,   0);
    check_eq("rst_fi",      FI,        0);
    check_eq("rst_fq",      FQ,        0);
    check_eq("rst_state",   dbg_state, 0);
    Reset = 1'b0;

    // Reset while three samples wait and the engine is in G1.
    write_coef(5'd0, 27'h0800000, 27'h0000000);
    write_coef(5'd3, 27'h1000000, 27'h0300000);
    for (int i = 0; i < 5; i++) push_sample(24'h100000 + 24'(i), 24'h080000, ok);
    stop_push();
    repeat (3) @(negedge clk);
    check_eq("pre_rst_state_g1", dbg_state, 2);
    cnt_before = out_cnt;
    Reset = 1'b1;
    model_clear();
    #1;
    check_eq("abort_stopin",  StopIn,    0);
    check_eq("abort_pushout", PushOut,   0);
    check_eq("abort_fi",      FI,        0);
    check_eq("abort_fq",      FQ,        0);
    check_eq("abort_state",   dbg_state, 0);
    @(negedge clk);
    Reset = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("abort_no_output", out_cnt, cnt_before);

    // C[0]=1.0: impulse at tap 0, then again at mirrored tap 28.
    write_coef(5'd0, 27'h1000000, 27'h0000000);
    target = out_cnt + 1;
    push_sample(24'h400000, 24'h000000, ok);
    c_push = cyc + 1;
    stop_push();
    wait_outs(target, 30);
    if (out_cyc_q.size() > 0)
      check_eq("latency", out_cyc_q[out_cyc_q.size()-1] - c_push, 5);
    check_eq("c0_fi", last_fi, 32'h00800000);
    check_eq("c0_fq", last_fq, 32'h00000000);
    for (int i = 1; i <= 29; i++) begin
      send_one(24'h000000, 24'h000000);
      if (i == 28) check_eq("c0_mirror_fi", last_fi, 32'h00800000);
      else         check_eq("c0_zero_fi",   last_fi, 32'h00000000);
    end

    // C[0]=j rotates a real sample onto the quadrature output.
    do_reset();
    write_coef(5'd0, 27'h0000000, 27'h1000000);
    send_one(24'h400000, 24'h000000);
    check_eq("cj_fi", last_fi, 32'h00000000);
    check_eq("cj_fq", last_fq, 32'h00800000);

    // Centre tap only: the 15th sample is the first to reach s[14].
    do_reset();
    write_coef(5'd14, 27'h1000000, 27'h0000000);
    for (int i = 1; i <= 15; i++) begin
      send_one(24'h200000, 24'h000000);
      if (i < 15) check_eq("c14_early_fi", last_fi, 32'h00000000);
      else        check_eq("c14_hit_fi",   last_fi, 32'h00400000);
    end

    // Illegal address write, then a C[0] rewrite while the engine is in G1.
    do_reset();
    write_coef(5'd0,  27'h1000000, 27'h0000000);
    write_coef(5'd20, 27'h1234567, 27'h0ABCDEF);
    for (int i = 0; i < 5; i++) begin
      send_one(24'h100000, 24'h000000);
      check_eq("addr20_fi", last_fi, 32'h00200000);
    end
    target = out_cnt + 1;
    push_sample(24'h400000, 24'h000000, ok);
    stop_push();
    @(negedge clk);
    @(negedge clk);
    check_eq("midcalc_state_g1", dbg_state, 2);
    write_coef_now(5'd0, 27'h0800000, 27'h0000000);
    wait_outs(target, 30);
    check_eq("coef_old_fi", last_fi, 32'h00800000);
    send_one(24'h400000, 24'h000000);
    check_eq("coef_new_fi", last_fi, 32'h00400000);

    // Back-to-back burst with random coefficients: fill, drop, pacing.
    do_reset();
    for (int k = 0; k < 15; k++)
      write_coef(5'(k), 27'($urandom_range(0, 32'h7FFFFFF)), 27'($urandom_range(0, 32'h7FFFFFF)));
    target = out_cnt + 10;
    n_acc  = 0;
    for (int i = 0; i < 12; i++) begin
      push_sample(24'($urandom_range(0, 32'hFFFFFF)), 24'($urandom_range(0, 32'hFFFFFF)), ok);
      check_eq("burst_stopin", 64'(!ok), 64'(i >= 10));
      if (ok) n_acc++;
    end
    stop_push();
    wait_outs(target, 120);
    check_eq("burst_accepted", n_acc, 10);
    check_eq("burst_outputs", out_cyc_q.size(), 10);
    for (int i = 1; i < out_cyc_q.size(); i++)
      check_eq("burst_spacing", out_cyc_q[i] - out_cyc_q[i-1], 5);
    repeat (20) @(negedge clk);
    check_eq("burst_no_extra", out_cnt, target);

    // Spaced random samples against the same coefficient set.
    for (int i = 0; i < 8; i++)
      send_one(24'($urandom_range(0, 32'hFFFFFF)), 24'($urandom_range(0, 32'hFFFFFF)));

    repeat (10) @(negedge clk);
    check_eq("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
